// File: rtl/uart_tx_drain_if.sv
// Read-side handshake between uart_tx_drain and the upstream FIFO it empties.
interface uart_tx_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rd_ready;
    logic                  rd_val;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_en;

    // The transmitter pulls words: it issues rd_en and consumes the FIFO's status/data.
    modport master (
        input  rd_ready,
        input  rd_val,
        input  rd_data,
        output rd_en
    );

    // The FIFO side answers rd_en with rd_val/rd_data one cycle later.
    modport slave (
        output rd_ready,
        output rd_val,
        output rd_data,
        input  rd_en
    );
endinterface

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: fetches one word at a time from an upstream FIFO and shifts it
// out as a serial frame (start, LSB-first data, optional even parity, stop).
module uart_tx_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_drain_if.master rd,
    output logic            tx,
    output logic            busy,
    output logic            tx_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  tx_done_q, tx_done_d;
    logic                  baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    // State and all registered outputs; reset drops the frame and parks the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            tx_done_q <= tx_done_d;
        end
    end

    // Next-state logic: the baud counter restarts at every bit boundary so bit lengths never drift.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd.rd_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // The request is already out; a late drop of rd_ready cannot retract it.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rd.rd_val) begin
                    shift_d  = rd.rd_data;
                    parity_d = ^rd.rd_data;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so the registered outputs line up with it.
    always_comb begin
        tx_d      = 1'b1;
        rd_en_d   = (state_d == S_FETCH);
        tx_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign rd.rd_en = rd_en_q;
    assign tx_done  = tx_done_q;
    assign busy     = (state_q != S_IDLE);
endmodule
